// File: rtl/nonogram_line_reducer.sv
// Line-solver engine: filters the option stream of one row/column against the
// board, pushes survivors back, and commits cells forced across all survivors.
module nonogram_line_reducer #(
  parameter int unsigned MAX_SIZE  = 16,
  parameter int unsigned OPT_CNT_W = 16,
  parameter int unsigned IDX_W     = $clog2(2 * MAX_SIZE),
  localparam int unsigned DIM_W    = $clog2(MAX_SIZE + 1),
  localparam int unsigned CELLS    = MAX_SIZE * MAX_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DIM_W-1:0]     num_rows,
  input  logic [DIM_W-1:0]     num_cols,
  input  logic                 start,
  input  logic [IDX_W-1:0]     line_idx,
  input  logic [OPT_CNT_W-1:0] num_opts,
  input  logic                 opt_valid,
  output logic                 opt_ready,
  input  logic [MAX_SIZE-1:0]  option,
  output logic                 keep_valid,
  input  logic                 keep_ready,
  output logic [MAX_SIZE-1:0]  keep_option,
  output logic [OPT_CNT_W-1:0] kept_count,
  output logic                 done,
  output logic                 contradiction,
  output logic [CELLS-1:0]     known,
  output logic [CELLS-1:0]     assigned,
  output logic                 solved
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_next;

  logic                 is_row_q;
  logic [IDX_W-1:0]     pos_q;
  logic [DIM_W-1:0]     len_q;
  logic [OPT_CNT_W-1:0] num_opts_q;
  logic [OPT_CNT_W-1:0] accepted_q;
  logic [MAX_SIZE-1:0]  and_acc_q;
  logic [MAX_SIZE-1:0]  or_acc_q;

  logic                 start_c;
  logic                 clear_c;
  logic                 accept_c;
  logic                 commit_c;
  logic                 consistent_c;

  logic [MAX_SIZE-1:0]  line_known_c;
  logic [MAX_SIZE-1:0]  line_assigned_c;
  logic [MAX_SIZE-1:0]  line_mask_c;
  logic [MAX_SIZE-1:0]  set_known_c;
  logic [MAX_SIZE-1:0]  set_one_c;
  logic [CELLS-1:0]     known_next_c;
  logic [CELLS-1:0]     assigned_next_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next = state_q;
    opt_ready  = 1'b0;
    start_c    = 1'b0;
    clear_c    = 1'b0;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          clear_c = 1'b1;
        end else if (start) begin
          start_c    = 1'b1;
          state_next = (num_opts == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accepted_q == num_opts_q) begin
          state_next = S_COMMIT;
        end else begin
          opt_ready = !keep_valid || keep_ready;
          accept_c  = opt_valid && opt_ready;
        end
      end
      S_COMMIT: begin
        // The last survivor must leave before the pass can complete.
        if (!keep_valid || keep_ready) begin
          commit_c   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Gather the selected line's known/assigned bits and its active-length mask.
  always_comb begin
    line_known_c    = '0;
    line_assigned_c = '0;
    line_mask_c     = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      line_mask_c[i] = DIM_W'(i) < len_q;
    end
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (is_row_q) begin
          if (pos_q == IDX_W'(r)) begin
            line_known_c[c]    = known[r*MAX_SIZE+c];
            line_assigned_c[c] = assigned[r*MAX_SIZE+c];
          end
        end else if (pos_q == IDX_W'(c)) begin
          line_known_c[r]    = known[r*MAX_SIZE+c];
          line_assigned_c[r] = assigned[r*MAX_SIZE+c];
        end
      end
    end
  end

  // An option survives if it agrees with every known cell of the active line.
  assign consistent_c = ~|((option ^ line_assigned_c) & line_known_c & line_mask_c);

  // Cells forced by the survivors: common 1 (and_acc) or common 0 (!or_acc), unknown only.
  assign set_one_c   = line_mask_c & ~line_known_c & and_acc_q;
  assign set_known_c = line_mask_c & ~line_known_c & (and_acc_q | ~or_acc_q);

  // Scatter the forced line cells back into board coordinates.
  always_comb begin
    known_next_c    = known;
    assigned_next_c = assigned;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (is_row_q) begin
          if (pos_q == IDX_W'(r)) begin
            known_next_c[r*MAX_SIZE+c]    = known[r*MAX_SIZE+c] | set_known_c[c];
            assigned_next_c[r*MAX_SIZE+c] = assigned[r*MAX_SIZE+c] | set_one_c[c];
          end
        end else if (pos_q == IDX_W'(c)) begin
          known_next_c[r*MAX_SIZE+c]    = known[r*MAX_SIZE+c] | set_known_c[r];
          assigned_next_c[r*MAX_SIZE+c] = assigned[r*MAX_SIZE+c] | set_one_c[r];
        end
      end
    end
  end

  // Pass datapath: line latch, accumulators, survivor push-back, board commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_row_q      <= 1'b0;
      pos_q         <= '0;
      len_q         <= '0;
      num_opts_q    <= '0;
      accepted_q    <= '0;
      and_acc_q     <= '0;
      or_acc_q      <= '0;
      keep_valid    <= 1'b0;
      keep_option   <= '0;
      kept_count    <= '0;
      done          <= 1'b0;
      contradiction <= 1'b0;
      known         <= '0;
      assigned      <= '0;
    end else begin
      done <= (state_next == S_DONE);

      if (clear_c) begin
        known    <= '0;
        assigned <= '0;
      end

      if (start_c) begin
        if (line_idx < IDX_W'(num_rows)) begin
          is_row_q <= 1'b1;
          pos_q    <= line_idx;
          len_q    <= num_cols;
        end else begin
          is_row_q <= 1'b0;
          pos_q    <= line_idx - IDX_W'(num_rows);
          len_q    <= num_rows;
        end
        num_opts_q    <= num_opts;
        accepted_q    <= '0;
        and_acc_q     <= '1;
        or_acc_q      <= '0;
        kept_count    <= '0;
        contradiction <= (num_opts == '0);
      end

      if (keep_valid && keep_ready) begin
        keep_valid <= 1'b0;
      end

      if (accept_c) begin
        accepted_q <= accepted_q + OPT_CNT_W'(1);
        if (consistent_c) begin
          and_acc_q   <= and_acc_q & option;
          or_acc_q    <= or_acc_q | option;
          kept_count  <= kept_count + OPT_CNT_W'(1);
          keep_option <= option;
          keep_valid  <= 1'b1;
        end
      end

      if (commit_c) begin
        if (kept_count != '0) begin
          known    <= known_next_c;
          assigned <= assigned_next_c;
        end
        contradiction <= (kept_count == '0);
      end
    end
  end

  // Whole active area known.
  always_comb begin
    solved = 1'b1;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (DIM_W'(r) < num_rows && DIM_W'(c) < num_cols && !known[r*MAX_SIZE+c]) begin
          solved = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nonogram_line_reducer.sv
// Bench for nonogram_line_reducer: directed vector table, multi-cycle corner
// sequences, and random puzzles checked against an array-based line model.
module tb_nonogram_line_reducer;

  localparam int unsigned MS = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned IW = 5;
  localparam int unsigned DW = 5;
  localparam int unsigned NC = MS * MS;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [DW-1:0] num_rows;
  logic [DW-1:0] num_cols;
  logic          start;
  logic [IW-1:0] line_idx;
  logic [OW-1:0] num_opts;
  logic          opt_valid;
  logic          opt_ready;
  logic [MS-1:0] option;
  logic          keep_valid;
  logic          keep_ready;
  logic [MS-1:0] keep_option;
  logic [OW-1:0] kept_count;
  logic          done;
  logic          contradiction;
  logic [NC-1:0] known;
  logic [NC-1:0] assigned;
  logic          solved;

  nonogram_line_reducer #(.MAX_SIZE(MS), .OPT_CNT_W(OW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .num_rows(num_rows), .num_cols(num_cols),
    .start(start), .line_idx(line_idx), .num_opts(num_opts),
    .opt_valid(opt_valid), .opt_ready(opt_ready), .option(option),
    .keep_valid(keep_valid), .keep_ready(keep_ready), .keep_option(keep_option),
    .kept_count(kept_count), .done(done), .contradiction(contradiction),
    .known(known), .assigned(assigned), .solved(solved)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference board and puzzle geometry.
  bit mk [MS][MS];
  bit ma [MS][MS];
  int nr, nc;

  logic [MS-1:0] cur_opts[$];
  logic [MS-1:0] exp_keep[$];
  logic [MS-1:0] keep_q[$];
  int            done_cnt = 0;

  // Observe handshakes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (keep_valid && keep_ready) keep_q.push_back(keep_option);
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] pack_board(input bit want_assigned);
    logic [NC-1:0] v = '0;
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        v[r*MS+c] = want_assigned ? ma[r][c] : mk[r][c];
    return v;
  endfunction

  function automatic bit model_solved();
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        if (!mk[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        mk[r][c] = 1'b0;
        ma[r][c] = 1'b0;
      end
  endtask

  // Filter cur_opts against the model board and apply forced cells.
  task automatic model_pass(input int idx);
    bit is_row;
    int p, len;
    is_row = idx < nr;
    p      = is_row ? idx : idx - nr;
    len    = is_row ? nc : nr;
    exp_keep.delete();
    foreach (cur_opts[k]) begin
      bit ok = 1'b1;
      for (int i = 0; i < len; i++) begin
        int r = is_row ? p : i;
        int c = is_row ? i : p;
        if (mk[r][c] && ma[r][c] != cur_opts[k][i]) ok = 1'b0;
      end
      if (ok) exp_keep.push_back(cur_opts[k]);
    end
    if (exp_keep.size() > 0) begin
      for (int i = 0; i < len; i++) begin
        int r = is_row ? p : i;
        int c = is_row ? i : p;
        int ones = 0;
        foreach (exp_keep[k]) ones += int'(exp_keep[k][i]);
        if (!mk[r][c]) begin
          if (ones == exp_keep.size()) begin
            mk[r][c] = 1'b1; ma[r][c] = 1'b1;
          end else if (ones == 0) begin
            mk[r][c] = 1'b1; ma[r][c] = 1'b0;
          end
        end
      end
    end
  endtask

  // Drive one full pass; stall_at>=0 holds keep_ready low for 4 cycles from that cycle.
  task automatic run_pass(input int idx, input int stall_at, input bit rnd_ready);
    int i, cyc, d0;
    keep_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    start    = 1'b1;
    line_idx = IW'(idx);
    num_opts = OW'(cur_opts.size());
    @(posedge clk); #1;
    start = 1'b0;
    i   = 0;
    cyc = 0;
    while (i < cur_opts.size() && cyc < 2000) begin
      opt_valid = 1'b1;
      option    = cur_opts[i];
      if (stall_at >= 0) keep_ready = !(cyc >= stall_at && cyc < stall_at + 4);
      else if (rnd_ready) keep_ready = ($urandom_range(0, 3) != 0);
      else keep_ready = 1'b1;
      @(negedge clk);
      if (stall_at >= 0 && !keep_ready && keep_valid) chk("opt_ready_during_stall", opt_ready, 0);
      if (opt_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    opt_valid  = 1'b0;
    keep_ready = 1'b1;
    cyc = 0;
    while (done_cnt == d0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    else chk("done_single_pulse", done_cnt - d0, 1);
  endtask

  // Compare DUT results of the last pass against the model.
  task automatic verify_pass(input string tag);
    chk({tag, "_kept_count"}, kept_count, exp_keep.size());
    chk({tag, "_contradiction"}, contradiction, exp_keep.size() == 0);
    chk({tag, "_keep_pushes"}, keep_q.size(), exp_keep.size());
    for (int k = 0; k < exp_keep.size() && k < keep_q.size(); k++)
      chk({tag, "_keep_order"}, keep_q[k], exp_keep[k]);
    chk({tag, "_known"}, known, pack_board(1'b0));
    chk({tag, "_assigned"}, assigned, pack_board(1'b1));
    chk({tag, "_solved"}, solved, model_solved());
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  typedef struct {
    int          idx;
    int          n;
    logic [63:0] o;
    int          exp_kept;
    bit          exp_contra;
    int          stall_at;
  } vec_t;

  vec_t vecs[6];
  bit   sol [MS][MS];

  initial begin
    logic [MS-1:0] w;
    rst = 1'b1; clear = 1'b0; start = 1'b0; line_idx = '0; num_opts = '0;
    opt_valid = 1'b0; option = '0; keep_ready = 1'b1;
    nr = 5; nc = 5;
    num_rows = DW'(nr); num_cols = DW'(nc);
    model_clear();

    // 5x5 directed table; bit i of an option is cell i along the line.
    vecs[0] = '{0, 2, {32'h0, 16'h000E, 16'h0007}, 2, 1'b0, -1};
    vecs[1] = '{0, 1, {48'h0, 16'h000E}, 1, 1'b0, -1};
    vecs[2] = '{5, 2, {32'h0, 16'h0014, 16'h0015}, 1, 1'b0, -1};
    vecs[3] = '{1, 3, {16'h0, 16'h001F, 16'h0003, 16'h0001}, 0, 1'b1, -1};
    vecs[4] = '{2, 0, 64'h0, 0, 1'b1, -1};
    vecs[5] = '{8, 4, {16'h0003, 16'h001F, 16'h0000, 16'h0001}, 3, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_known", known, 0);
    chk("reset_done", done, 0);
    chk("reset_keep_valid", keep_valid, 0);
    chk("reset_kept_count", kept_count, 0);
    chk("reset_contradiction", contradiction, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_opt_ready", opt_ready, 0);
    chk("idle_solved", solved, 0);

    for (int v = 0; v < 6; v++) begin
      cur_opts.delete();
      for (int k = 0; k < vecs[v].n; k++) begin
        w = vecs[v].o[k*16 +: 16];
        cur_opts.push_back(w);
      end
      model_pass(vecs[v].idx);
      run_pass(vecs[v].idx, vecs[v].stall_at, 1'b0);
      chk($sformatf("vec%0d_kept", v), kept_count, vecs[v].exp_kept);
      chk($sformatf("vec%0d_contra", v), contradiction, vecs[v].exp_contra);
      verify_pass($sformatf("vec%0d", v));
      if (v == 0) begin
        chk("row0_known_bits", known[4:0], 5'b10110);
        chk("row0_assigned_bits", assigned[4:0], 5'b00110);
      end
    end

    // Start outside IDLE ignored, clear outside IDLE ignored: neither may disturb a pass.
    cur_opts = '{16'h0003};
    model_pass(7);
    fork
      run_pass(7, -1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
      end
    join
    verify_pass("busy_start_clear");

    // 11x11 X board, one true option per line.
    nr = 11; nc = 11;
    num_rows = DW'(nr); num_cols = DW'(nc);
    do_clear();
    chk("clear_known", known, 0);
    for (int l = 0; l < 22; l++) begin
      int p = (l < 11) ? l : l - 11;
      w = '0;
      w[p] = 1'b1;
      w[10-p] = 1'b1;
      cur_opts = '{w};
      model_pass(l);
      run_pass(l, -1, 1'b0);
      verify_pass($sformatf("xboard_line%0d", l));
    end
    chk("xboard_solved", solved, 1);

    // Reset during ACCUM aborts the pass.
    cur_opts = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F};
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; line_idx = IW'(3); num_opts = OW'(5);
      @(posedge clk); #1;
      start = 1'b0; opt_valid = 1'b1; option = cur_opts[0];
      @(posedge clk); #1;
      option = cur_opts[1];
      @(posedge clk); #1;
      rst = 1'b1; opt_valid = 1'b0;
      #1;
      chk("rst_mid_known", known, 0);
      chk("rst_mid_keep_valid", keep_valid, 0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_mid_no_done", done_cnt - d0, 0);
      model_clear();
      cur_opts = '{16'h0700, 16'h0380};
      model_pass(3);
      run_pass(3, -1, 1'b0);
      verify_pass("after_rst");
    end

    // Random puzzles with random backpressure.
    for (int pz = 0; pz < 4; pz++) begin
      nr = $urandom_range(3, 16);
      nc = $urandom_range(3, 16);
      num_rows = DW'(nr); num_cols = DW'(nc);
      do_clear();
      for (int r = 0; r < MS; r++)
        for (int c = 0; c < MS; c++)
          sol[r][c] = ($urandom_range(0, 1) == 1);
      for (int ps = 0; ps < 30; ps++) begin
        int idx, len, p, k;
        bit is_row;
        logic [MS-1:0] t;
        idx    = $urandom_range(0, nr + nc - 1);
        is_row = idx < nr;
        p      = is_row ? idx : idx - nr;
        len    = is_row ? nc : nr;
        t      = MS'($urandom);
        for (int i = 0; i < len; i++) t[i] = is_row ? sol[p][i] : sol[i][p];
        cur_opts.delete();
        k = $urandom_range(0, 6);
        for (int j = 0; j < k; j++) begin
          case ($urandom_range(0, 3))
            0: cur_opts.push_back(MS'($urandom));
            1: begin
              w = t;
              w[$urandom_range(0, len - 1)] ^= 1'b1;
              cur_opts.push_back(w);
            end
            default: cur_opts.push_back(t);
          endcase
        end
        model_pass(idx);
        run_pass(idx, -1, 1'b1);
        verify_pass($sformatf("rnd%0d_%0d", pz, ps));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
